// File: rtl/ysyx_22050710_mdu_if.sv
// Request/response bundle between the pipeline and the iterative multiply/divide unit.
// The slave modport is the unit's view; the master modport is the pipeline's view.
interface ysyx_22050710_mdu_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic            i_word;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;

  modport slave (
    input  i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_op, i_word, i_src1, i_src2, i_flush, i_ready,
    input  o_ready, o_valid, o_result
  );
endinterface

// File: rtl/ysyx_22050710_mdu.sv
// Iterative M-extension unit: radix-2 shift-add multiplier and restoring divider.
// Define YSYX_22050710_MDU_FASTPATH_EN to finish divide-by-zero, signed overflow and multiply-by-zero in one cycle.
module ysyx_22050710_mdu #(
  parameter int XLEN = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ysyx_22050710_mdu_if.slave  io_bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int PW = 2 * XLEN;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] LO32 = ONES >> (XLEN - 32);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_word;
  logic            r_sa;
  logic            r_sb;
  logic            r_divz;
  logic            r_fast;
  logic            r_valid;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_opa;
  logic [XLEN-1:0] r_opb;
  logic [XLEN-1:0] r_result;

  function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] t;
    t = $signed(v << (XLEN - 32));
    return t >>> (XLEN - 32);
  endfunction

  function automatic logic [XLEN-1:0] f_cneg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Accept-side decode: width selection, signedness and operand magnitudes
  logic            w_word;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic [XLEN-1:0] w_ea;
  logic [XLEN-1:0] w_eb;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_divz;
  logic [CW-1:0]   w_n;
  logic            w_fast;
  logic [XLEN-1:0] w_special;

  assign w_word  = (XLEN == 64) ? io_bus.i_word : 1'b0;
  assign w_a_sgn = (io_bus.i_op == 3'b001) || (io_bus.i_op == 3'b010) ||
                   (io_bus.i_op == 3'b100) || (io_bus.i_op == 3'b110);
  assign w_b_sgn = (io_bus.i_op == 3'b001) || (io_bus.i_op == 3'b100) ||
                   (io_bus.i_op == 3'b110);
  assign w_ea    = w_word ? (w_a_sgn ? f_sext32(io_bus.i_src1) : (io_bus.i_src1 & LO32))
                          : io_bus.i_src1;
  assign w_eb    = w_word ? (w_b_sgn ? f_sext32(io_bus.i_src2) : (io_bus.i_src2 & LO32))
                          : io_bus.i_src2;
  assign w_sa    = w_a_sgn & w_ea[XLEN-1];
  assign w_sb    = w_b_sgn & w_eb[XLEN-1];
  assign w_mag_a = f_cneg(w_ea, w_sa);
  assign w_mag_b = f_cneg(w_eb, w_sb);
  assign w_divz  = (w_eb == '0);
  assign w_n     = w_word ? CW'(32) : CW'(XLEN);

`ifdef YSYX_22050710_MDU_FASTPATH_EN
  logic [XLEN-1:0] w_minneg;
  logic            w_ovf;
  logic            w_mulz;
  logic [XLEN-1:0] w_spec_raw;

  assign w_minneg = ONES << (w_word ? 31 : XLEN - 1);
  assign w_ovf    = io_bus.i_op[2] & ~io_bus.i_op[0] & (w_ea == w_minneg) & (w_eb == ONES);
  assign w_mulz   = ~io_bus.i_op[2] & ((w_ea == '0) | (w_eb == '0));
  assign w_fast   = io_bus.i_op[2] ? (w_divz | w_ovf) : w_mulz;

  always_comb begin
    w_spec_raw = '0;
    if (io_bus.i_op[2]) begin
      if (w_divz)     w_spec_raw = io_bus.i_op[1] ? w_ea : ONES;
      else if (w_ovf) w_spec_raw = io_bus.i_op[1] ? '0 : w_ea;
    end
  end

  assign w_special = w_word ? f_sext32(w_spec_raw) : w_spec_raw;
`else
  assign w_fast    = 1'b0;
  assign w_special = '0;
`endif

  // Per-iteration datapath: one product bit or one quotient bit per cycle
  logic [PW-1:0]   w_add;
  logic [XLEN:0]   w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;

  assign w_add     = r_acc + (r_opb[0] ? r_opa : '0);
  assign w_trial   = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
  assign w_ge      = w_trial >= {1'b0, r_opa[XLEN-1:0]};
  assign w_rem_nxt = w_ge ? (w_trial[XLEN-1:0] - r_opa[XLEN-1:0]) : w_trial[XLEN-1:0];

  // Completion: sign fixup, result select, word-mode sign extension
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_prod_hi;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_final;

  assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_prod_hi = r_word ? XLEN'(w_prod[63:32]) : w_prod[PW-1:XLEN];
  assign w_quo     = r_divz ? ONES : f_cneg(r_opb, r_sa ^ r_sb);
  assign w_rem     = f_cneg(r_acc[XLEN-1:0], r_sa);

  always_comb begin
    w_raw = '0;
    if (r_op[2])               w_raw = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00) w_raw = w_prod[XLEN-1:0];
    else                       w_raw = w_prod_hi;
  end

  assign w_final = r_word ? f_sext32(w_raw) : w_raw;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (io_bus.i_flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.i_valid) begin
            r_op   <= io_bus.i_op;
            r_word <= w_word;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_divz <= w_divz;
            r_fast <= w_fast;
            r_acc  <= '0;
            // Dividend is left-aligned so the MSB-first divider sees word operands at the top
            if (io_bus.i_op[2]) begin
              r_opa <= PW'(w_mag_b);
              r_opb <= w_word ? (w_mag_a << (XLEN - 32)) : w_mag_a;
            end else begin
              r_opa <= PW'(w_mag_a);
              r_opb <= w_mag_b;
            end
            r_cnt <= w_fast ? '0 : w_n;
            if (w_fast) r_result <= w_special;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op[2]) begin
              r_acc <= PW'(w_rem_nxt);
              r_opb <= {r_opb[XLEN-2:0], w_ge};
            end else begin
              r_acc <= w_add;
              r_opa <= r_opa << 1;
              r_opb <= r_opb >> 1;
            end
          end else begin
            if (!r_fast) r_result <= w_final;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (io_bus.i_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.o_ready  = (r_state == IDLE) & i_rst_n;
  assign io_bus.o_valid  = r_valid;
  assign io_bus.o_result = r_result;

endmodule

// File: tb/tb_ysyx_22050710_mdu.sv
// Directed-vector bench for ysyx_22050710_mdu (XLEN=64) with an arithmetic reference model.
module tb_ysyx_22050710_mdu;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
  localparam logic [63:0] MIN64 = 64'h8000000000000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ysyx_22050710_mdu_if #(.XLEN(64)) bus ();
  ysyx_22050710_mdu #(.XLEN(64)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] exp_res;
  int exp_lat;
  int acc_edge;
  bit exp_pend = 1'b0;
  bit exp_chk = 1'b0;
  bit seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ext(input logic [63:0] v, input bit s, input bit w);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic bit a_signed(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic bit b_signed(input logic [2:0] op);
    return op == OP_MULH || op == OP_DIV || op == OP_REM;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input bit w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, r;
    logic [127:0] pa, pb, p;
    ea = ext(a, a_signed(op), w);
    eb = ext(b, b_signed(op), w);
    pa = a_signed(op) ? {{64{ea[63]}}, ea} : {64'b0, ea};
    pb = b_signed(op) ? {{64{eb[63]}}, eb} : {64'b0, eb};
    p  = pa * pb;
    case (op)
      OP_MUL:                     r = p[63:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = p[127:64];
      OP_DIV:  r = (eb == 0) ? '1 : (ea == MIN64 && eb == '1) ? ea : 64'($signed(ea) / $signed(eb));
      OP_DIVU: r = (eb == 0) ? '1 : ea / eb;
      OP_REM:  r = (eb == 0) ? ea : (ea == MIN64 && eb == '1) ? 64'd0 : 64'($signed(ea) % $signed(eb));
      default: r = (eb == 0) ? ea : ea % eb;
    endcase
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic int latency(input logic [2:0] op, input bit w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb;
    ea = ext(a, a_signed(op), w);
    eb = ext(b, b_signed(op), w);
`ifdef YSYX_22050710_MDU_FASTPATH_EN
    if (op[2]) begin
      if (eb == 0) return 1;
      if (b_signed(op) && eb == '1 && ea == (w ? 64'hFFFFFFFF80000000 : MIN64)) return 1;
    end else if (ea == 0 || eb == 0) begin
      return 1;
    end
`else
    if (ea == eb) return w ? 33 : 65;
`endif
    return w ? 33 : 65;
  endfunction

  // Compare process: result and latency on every cycle the result is presented
  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (!exp_pend) begin
        chk("spurious_valid", 64'd1, 64'd0);
      end else begin
        if (exp_chk) chk("result", bus.o_result, exp_res);
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 64'(cyc - acc_edge), 64'(exp_lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input bit w, input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    while (!bus.o_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_ready) chk("ready_timeout", 64'd0, 64'd1);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_word  = w;
    bus.i_src1  = a;
    bus.i_src2  = b;
    exp_res  = model(op, w, a, b);
    exp_lat  = latency(op, w, a, b);
    exp_chk  = !(w && !op[2] && op != OP_MUL);
    seen     = 1'b0;
    acc_edge = cyc + 1;
    exp_pend = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_op    = ~op;
    bus.i_word  = ~w;
    bus.i_src1  = ~a;
    bus.i_src2  = a ^ b;
  endtask

  task automatic finish_op(input logic [63:0] lit, input int hold);
    int t = 0;
    while (!bus.o_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.o_valid) begin
      chk("valid_timeout", 64'd0, 64'd1);
      exp_pend = 1'b0;
      return;
    end
    chk("literal", bus.o_result, lit);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.o_valid), 64'd1);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    exp_pend = 1'b0;
    chk("hs_valid_low", 64'(bus.o_valid), 64'd0);
    chk("hs_ready_high", 64'(bus.o_ready), 64'd1);
  endtask

  task automatic vec(input logic [2:0] op, input bit w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] lit, input int hold);
    issue(op, w, a, b);
    finish_op(lit, hold);
  endtask

  task automatic watch_quiet(input string name);
    int bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.o_valid) bad++;
    end
    chk(name, 64'(bad), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = 3'd0;
    bus.i_word  = 1'b0;
    bus.i_src1  = '0;
    bus.i_src2  = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_result", bus.o_result, 64'd0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.o_ready), 64'd1);

    vec(OP_MUL,    0, '1, 64'd3, 64'hFFFFFFFFFFFFFFFD, 0);
    vec(OP_MULHU,  0, '1, 64'd3, 64'h0000000000000002, 0);
    vec(OP_MULH,   0, '1, 64'd3, 64'hFFFFFFFFFFFFFFFF, 10);
    vec(OP_MULHSU, 0, '1, 64'd3, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_MULHU,  0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 0);
    vec(OP_MULH,   0, 64'h4000000000000000, 64'd4, 64'h0000000000000001, 0);
    vec(OP_MUL,    0, 64'h123, 64'd0, 64'd0, 0);
    vec(OP_DIV,    0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 0);
    vec(OP_REM,    0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_DIVU,   0, 64'd7, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_REMU,   0, 64'd7, 64'd0, 64'd7, 0);
    vec(OP_DIV,    0, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_REM,    0, 64'hFFFFFFFFFFFFFFF9, 64'd0, 64'hFFFFFFFFFFFFFFF9, 0);
    vec(OP_DIV,    0, MIN64, '1, MIN64, 0);
    vec(OP_REM,    0, MIN64, '1, 64'd0, 0);
    vec(OP_DIV,    0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 0);
    vec(OP_REM,    0, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'd1, 0);
    vec(OP_DIV,    1, 64'hDEADBEEF80000000, 64'h12345678FFFFFFFF, 64'hFFFFFFFF80000000, 0);
    vec(OP_REM,    1, 64'hDEADBEEF80000000, 64'h12345678FFFFFFFF, 64'd0, 0);
    vec(OP_MUL,    1, 64'hAAAA00007FFFFFFF, 64'h5555000000000002, 64'hFFFFFFFFFFFFFFFE, 0);
    vec(OP_DIVU,   1, 64'hFFFFFFFF00000064, 64'h0000000100000007, 64'd14, 0);
    vec(OP_REMU,   1, 64'hFFFFFFFF00000064, 64'h0000000100000007, 64'd2, 0);
    vec(OP_REM,    1, 64'h00000000FFFFFFF9, 64'h0000001200000002, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_DIVU,   1, 64'h1234567887654321, 64'hABCD000000000000, 64'hFFFFFFFFFFFFFFFF, 0);
    vec(OP_REMU,   1, 64'h1234567887654321, 64'hABCD000000000000, 64'hFFFFFFFF87654321, 0);

    // Flush partway through a long divide
    issue(OP_DIV, 0, 64'd1000, 64'd7);
    repeat (19) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    exp_pend = 1'b0;
    chk("flush_valid", 64'(bus.o_valid), 64'd0);
    chk("flush_ready", 64'(bus.o_ready), 64'd1);
    watch_quiet("flush_no_valid");

    // Flush together with a request: nothing may be accepted
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = OP_DIVU;
    bus.i_src1  = 64'd50;
    bus.i_src2  = 64'd5;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_accept_ready", 64'(bus.o_ready), 64'd1);
    watch_quiet("flush_accept_no_valid");

    // Reset in the middle of an operation
    issue(OP_MULHU, 0, '1, '1);
    repeat (10) @(negedge clk);
    exp_pend = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_result", bus.o_result, 64'd0);
    chk("midrst_ready", 64'(bus.o_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", 64'(bus.o_ready), 64'd1);

    vec(OP_DIVU, 0, 64'd100, 64'd7, 64'd14, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_mdu.md
# ysyx_22050710_mdu

Iterative, parametrised multiply/divide unit sitting beside the single-cycle execute unit; it takes over all M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and RV64 W-forms) so the execute ALU no longer needs combinational `*`, `/` and `%`. It exchanges operands and results with the pipeline through valid/ready handshakes, runs a radix-2 shift-add multiplier or restoring divider over several cycles, and supports a pipeline flush.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE and i_rst_n=1).
- i_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_word  in  1  W-form (32-bit) operation; ignored when XLEN=32.
- i_src1, i_src2  in  XLEN  operands (rs1, rs2).
- i_flush  in  1  abort any in-flight operation.
- o_valid  out  1  o_result valid.
- i_ready  in  1  consumer takes result.
- o_result  out  XLEN  result.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: accept when i_valid & o_ready & ~i_flush; latch op, word flag, operands; load iteration counter with N (N = 32 if word mode, else XLEN); go BUSY.
- Word mode: operands use low 32 bits, sign- or zero-extended per op signedness; final result = low 32 bits sign-extended to XLEN. MULH* with i_word=1 is not a legal encoding; result unspecified, handshake still completes.
- Multiply: operands converted to magnitudes, unsigned shift-add one bit per cycle into a 2N-bit product; negate at completion if sign(a)^sign(b) (per op signedness: MULHSU treats src2 unsigned). MUL returns low N bits, MULH* high N bits.
- Divide: magnitudes, restoring divide one quotient bit per cycle; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
- Divide by zero: quotient all ones; remainder = dividend.
- Signed overflow (most-negative / -1 at width N): quotient = dividend; remainder 0.
- BUSY: one iteration per cycle, counter decrements; at counter = 0 apply sign fixup, register o_result, go DONE.
- DONE: o_valid=1, o_result stable; on i_ready go IDLE.
- i_flush: any state -> IDLE next edge; o_valid low next cycle; in-flight result discarded. Flush beats accept and beats result handshake in the same cycle.

## Timing
- Reset (i_rst_n=0 at edge): state IDLE, o_valid 0, o_result 0, counter 0; o_ready 0 while i_rst_n=0, 1 from the first cycle after release.
- Accept at edge k: o_ready low from k; N iteration edges k+1..k+N; fixup edge k+N+1; o_valid high from k+N+1 (latency N+1 cycles: 65 for 64-bit, 33 for word/XLEN=32).
- Result handshake at edge m (o_valid & i_ready): o_valid low and o_ready high from m; next accept earliest edge m+1.
- No result back-pressure loss: o_result held indefinitely while i_ready=0.
- Inputs other than i_valid/i_flush/i_ready are ignored outside the accept cycle.

## Configuration
- YSYX_22050710_MDU_FASTPATH_EN defined: divide by zero and signed overflow detected at accept; unit goes directly to DONE with the special result; o_valid from edge k+1 (latency 1). Multiplication with either operand zero also completes at k+1 with result 0.
- Undefined: all operations take the full N+1 cycles; special-case results identical.

## Test plan
- XLEN=64, MUL 0xFFFFFFFFFFFFFFFF × 3 -> o_result 0xFFFFFFFFFFFFFFFD after 65 cycles; MULHU same operands -> 0x0000000000000002; MULH -> 0xFFFFFFFFFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFFFFFFFFFD; REM -7/2 -> 0xFFFFFFFFFFFFFFFF; DIVU 7/0 -> all ones; REMU 7/0 -> 7; latency 1 with FASTPATH_EN, 65 without.
- Word DIVW 0x80000000 / 0xFFFFFFFF (src upper bits garbage) -> 0xFFFFFFFF80000000; REMW -> 0; MULW 0x7FFFFFFF×2 -> 0xFFFFFFFFFFFFFFFE; latency 33.
- Hold i_ready=0 for 10 cycles after o_valid -> o_result/o_valid stable; release -> o_ready high same cycle as handshake edge, new request accepted next edge.
- Assert i_flush at cycle 20 of a 64-bit DIV -> IDLE next edge, no o_valid; flush coincident with i_valid -> request not accepted.
- Assert i_rst_n=0 mid-BUSY -> next edge o_valid 0, o_result 0, state IDLE; o_ready 1 one cycle after release.
